// File: rtl/hgc_seq_pkg.sv
// Shared constants for the HGC character sequencer.
// Counts are clk_seq values (5 bits). Two pixel clocks per dot or pixel.
package hgc_seq_pkg;
  localparam int unsigned CNT_W = 5;

  localparam logic [CNT_W-1:0] TEXT_LAST  = 5'd17; // 9 dots x 2 clocks
  localparam logic [CNT_W-1:0] GRPH_LAST  = 5'd31; // 16 pixels x 2 clocks

  // Display fetch: char byte address at 0-3, attribute byte address at 4-7
  localparam logic [CNT_W-1:0] READ_CHAR  = 5'd3;
  localparam logic [CNT_W-1:0] ADDR_ATT   = 5'd4;
  localparam logic [CNT_W-1:0] READ_ATT   = 5'd7;
  localparam logic [CNT_W-1:0] FETCH_LAST = 5'd7;

  // CPU slots
  localparam logic [CNT_W-1:0] SLOT_A     = 5'd8;
  localparam logic [CNT_W-1:0] SLOT_B     = 5'd24; // graphics only
  localparam logic [CNT_W-1:0] SLOT_T2    = 5'd12; // text second slot (optional)
  localparam int unsigned      SLOT_LEN   = 4;
endpackage

// File: rtl/hgc_cpu_slot.sv
// CPU access slot for the single-port VRAM.
// A slot opens on the edge where the next count is a slot start; cpu_req is
// sampled on that same edge (i.e. during count S-1). The grant then covers
// SLOT_LEN counts and ack pulses in the last one.
// Ports:
//   clk, reset   pixel clock, synchronous active-high reset (aborts, no ack)
//   slot_start   next count is the first count of an enabled slot
//   req          CPU request level
//   grant        VRAM mux owned by CPU (registered)
//   ack          one-cycle completion pulse (registered)
module hgc_cpu_slot
  import hgc_seq_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic slot_start,
  input  logic req,
  output logic grant,
  output logic ack
);
  localparam int unsigned POS_W = $clog2(SLOT_LEN);
  localparam logic [POS_W-1:0] POS_ACK = POS_W'(SLOT_LEN - 2);
  localparam logic [POS_W-1:0] POS_END = POS_W'(SLOT_LEN - 1);

  logic [POS_W-1:0] pos; // position inside the grant window

  always_ff @(posedge clk) begin
    if (reset) begin
      grant <= 1'b0;
      ack   <= 1'b0;
      pos   <= '0;
    end else if (slot_start && req) begin
      grant <= 1'b1;
      ack   <= 1'b0;
      pos   <= '0;
    end else if (grant) begin
      if (pos == POS_END) begin
        grant <= 1'b0;
        ack   <= 1'b0;
      end else begin
        pos <= pos + 1'b1;
        ack <= (pos == POS_ACK);
      end
    end else begin
      ack <= 1'b0;
    end
  end
endmodule

// File: rtl/hgc_sequencer.sv
// HGC per-character sequencer: clock sequence count, display fetch strobes,
// CRTC character clock and CPU VRAM slot arbitration.
// Every output is registered from a decode of the next count, so each strobe
// is high exactly while clk_seq shows its count.
// Optional macro HGC_DUAL_SLOT_EN: adds a text-mode CPU slot at counts 12-15.
// Ports:
//   clk, reset      pixel clock, synchronous active-high reset
//   grph_mode       0 text (18 counts), 1 graphics (32 counts); taken at wrap
//   cpu_req         CPU access request level, held until cpu_ack
//   clk_seq         current sequence count
//   vram_read, vram_read_a0, vram_read_char, vram_read_att   display fetch
//   charrom_read, disp_pipeline, crtc_clk                    end of character
//   cpu_grant, cpu_ack                                       CPU handshake
module hgc_sequencer
  import hgc_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             grph_mode,
  input  logic             cpu_req,
  output logic [CNT_W-1:0] clk_seq,
  output logic             vram_read,
  output logic             vram_read_a0,
  output logic             vram_read_char,
  output logic             vram_read_att,
  output logic             charrom_read,
  output logic             disp_pipeline,
  output logic             crtc_clk,
  output logic             cpu_grant,
  output logic             cpu_ack
);
  logic [CNT_W-1:0] active_last;
  logic [CNT_W-1:0] nxt;
  logic [CNT_W-1:0] nxt_last;
  logic             wrap;
  logic             slot_start;

  // Mode only changes the length of the character that starts at the wrap,
  // so the decode uses the last count that will apply to the next count.
  always_comb begin
    wrap     = (clk_seq == active_last);
    nxt      = wrap ? '0 : clk_seq + 1'b1;
    nxt_last = wrap ? (grph_mode ? GRPH_LAST : TEXT_LAST) : active_last;
  end

  always_comb begin
    slot_start = (nxt == SLOT_A) ||
                 ((nxt == SLOT_B) && (nxt_last == GRPH_LAST));
`ifdef HGC_DUAL_SLOT_EN
    slot_start = slot_start || ((nxt == SLOT_T2) && (nxt_last == TEXT_LAST));
`else
    slot_start = slot_start;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_seq        <= '0;
      active_last    <= TEXT_LAST;
      vram_read      <= 1'b0;
      vram_read_a0   <= 1'b0;
      vram_read_char <= 1'b0;
      vram_read_att  <= 1'b0;
      charrom_read   <= 1'b0;
      disp_pipeline  <= 1'b0;
      crtc_clk       <= 1'b0;
    end else begin
      clk_seq        <= nxt;
      active_last    <= nxt_last;
      vram_read      <= (nxt <= FETCH_LAST);
      vram_read_a0   <= (nxt >= ADDR_ATT) && (nxt <= FETCH_LAST);
      vram_read_char <= (nxt == READ_CHAR);
      vram_read_att  <= (nxt == READ_ATT);
      charrom_read   <= (nxt == nxt_last);
      disp_pipeline  <= (nxt == nxt_last);
      crtc_clk       <= (nxt == nxt_last);
    end
  end

  hgc_cpu_slot u_slot (
    .clk        (clk),
    .reset      (reset),
    .slot_start (slot_start),
    .req        (cpu_req),
    .grant      (cpu_grant),
    .ack        (cpu_ack)
  );

  // CPU slots never overlap the display fetch window.
  a_no_overlap: assert property (@(posedge clk) disable iff (reset)
    !(cpu_grant && vram_read));
endmodule

// File: tb/tb_hgc_sequencer.sv
module tb_hgc_sequencer;
  logic       clk = 1'b0;
  logic       reset, grph_mode, cpu_req;
  logic [4:0] clk_seq;
  logic       vram_read, vram_read_a0, vram_read_char, vram_read_att;
  logic       charrom_read, disp_pipeline, crtc_clk, cpu_grant, cpu_ack;

  int nvec = 0;
  int nmis = 0;
  int ec, el;       // expected count and expected last count
  int since;
  bit wrapped;
  bit eg, ea;

`ifdef HGC_DUAL_SLOT_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  hgc_sequencer dut (
    .clk(clk), .reset(reset), .grph_mode(grph_mode), .cpu_req(cpu_req),
    .clk_seq(clk_seq), .vram_read(vram_read), .vram_read_a0(vram_read_a0),
    .vram_read_char(vram_read_char), .vram_read_att(vram_read_att),
    .charrom_read(charrom_read), .disp_pipeline(disp_pipeline),
    .crtc_clk(crtc_clk), .cpu_grant(cpu_grant), .cpu_ack(cpu_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       grph, req;
    logic [4:0] seq;
    logic       vr, a0, rc, ra, cr, gnt, ack;
  } vec_t;
  vec_t tbl[19];

  function automatic vec_t mk(logic g, logic r, logic [4:0] s, logic vr, logic a0,
                              logic rc, logic ra, logic cr, logic gn, logic ak);
    vec_t v;
    v.grph = g; v.req = r; v.seq = s; v.vr = vr; v.a0 = a0;
    v.rc = rc; v.ra = ra; v.cr = cr; v.gnt = gn; v.ack = ak;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    chk("grant_vs_fetch", {31'd0, cpu_grant & vram_read}, 0);
  endtask

  task automatic chk_cnt(input int e, input int last);
    chk("clk_seq", clk_seq, e);
    chk("vram_read", vram_read, e <= 7);
    chk("vram_read_a0", vram_read_a0, e >= 4 && e <= 7);
    chk("vram_read_char", vram_read_char, e == 3);
    chk("vram_read_att", vram_read_att, e == 7);
    chk("charrom_read", charrom_read, e == last);
    chk("disp_pipeline", disp_pipeline, e == last);
    chk("crtc_clk", crtc_clk, e == last);
  endtask

  // Advance one clock along the expected count model and check the strobes.
  task automatic adv_chk();
    if (ec == el) begin
      ec = 0;
      el = grph_mode ? 31 : 17;
    end else ec++;
    step();
    chk_cnt(ec, el);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // text character with a CPU request raised at count 5
    tbl[0]  = mk(0,0, 1,1,0,0,0,0,0,0);
    tbl[1]  = mk(0,0, 2,1,0,0,0,0,0,0);
    tbl[2]  = mk(0,0, 3,1,0,1,0,0,0,0);
    tbl[3]  = mk(0,0, 4,1,1,0,0,0,0,0);
    tbl[4]  = mk(0,0, 5,1,1,0,0,0,0,0);
    tbl[5]  = mk(0,1, 6,1,1,0,0,0,0,0);
    tbl[6]  = mk(0,1, 7,1,1,0,1,0,0,0);
    tbl[7]  = mk(0,1, 8,0,0,0,0,0,1,0);
    tbl[8]  = mk(0,1, 9,0,0,0,0,0,1,0);
    tbl[9]  = mk(0,1,10,0,0,0,0,0,1,0);
    tbl[10] = mk(0,1,11,0,0,0,0,0,1,1);
    tbl[11] = mk(0,0,12,0,0,0,0,0,0,0);
    tbl[12] = mk(0,0,13,0,0,0,0,0,0,0);
    tbl[13] = mk(0,0,14,0,0,0,0,0,0,0);
    tbl[14] = mk(0,0,15,0,0,0,0,0,0,0);
    tbl[15] = mk(0,0,16,0,0,0,0,0,0,0);
    tbl[16] = mk(0,0,17,0,0,0,0,1,0,0);
    tbl[17] = mk(0,0, 0,1,0,0,0,0,0,0);
    tbl[18] = mk(0,0, 1,1,0,0,0,0,0,0);

    reset = 1'b1; grph_mode = 1'b0; cpu_req = 1'b0;
    step(); step();
    chk("rst_seq", clk_seq, 0);
    chk("rst_vram_read", vram_read, 0);
    chk("rst_read_char", vram_read_char, 0);
    chk("rst_crtc", crtc_clk, 0);
    chk("rst_charrom", charrom_read, 0);
    chk("rst_grant", cpu_grant, 0);
    chk("rst_ack", cpu_ack, 0);
    reset = 1'b0;

    for (int k = 0; k < 19; k++) begin
      grph_mode = tbl[k].grph;
      cpu_req   = tbl[k].req;
      step();
      chk("tv_seq", clk_seq, tbl[k].seq);
      chk("tv_vram_read", vram_read, tbl[k].vr);
      chk("tv_a0", vram_read_a0, tbl[k].a0);
      chk("tv_read_char", vram_read_char, tbl[k].rc);
      chk("tv_read_att", vram_read_att, tbl[k].ra);
      chk("tv_charrom", charrom_read, tbl[k].cr);
      chk("tv_disp_pipe", disp_pipeline, tbl[k].cr);
      chk("tv_crtc", crtc_clk, tbl[k].cr);
      chk("tv_grant", cpu_grant, tbl[k].gnt);
      chk("tv_ack", cpu_ack, tbl[k].ack);
    end

    // text run, request dropped: no further grants
    ec = 1; el = 17;
    for (int i = 0; i < 40; i++) begin
      adv_chk();
      chk("txt_no_grant", cpu_grant, 0);
    end

    // mode change mid-character: current text character still ends at 17
    while (ec != 10) adv_chk();
    grph_mode = 1'b1;
    while (!(ec == 0 && el == 31)) adv_chk();
    chk("mode_switch_len", el, 31);
    since = -1;
    for (int i = 0; i < 96; i++) begin
      adv_chk();
      if (since >= 0) since++;
      if (crtc_clk) begin
        if (since > 0) chk("crtc_period_grph", since, 32);
        since = 0;
      end
    end

    // graphics: request at count 8 misses slot A, served in slot B
    while (ec != 8) adv_chk();
    cpu_req = 1'b1;
    for (int i = 0; i < 32; i++) begin
      adv_chk();
      chk("grph_grant", cpu_grant, ec >= 24 && ec <= 27);
      chk("grph_ack", cpu_ack, ec == 27);
      if (ec == 27) cpu_req = 1'b0;
    end

    // text: request at count 9 waits for the next slot
    grph_mode = 1'b0;
    while (!(ec == 0 && el == 17)) adv_chk();
    while (ec != 9) adv_chk();
    cpu_req = 1'b1;
    wrapped = 1'b0;
    for (int i = 0; i < 20; i++) begin
      adv_chk();
      if (ec == 0) wrapped = 1'b1;
      eg = DUAL ? (!wrapped && ec >= 12 && ec <= 15) : (wrapped && ec >= 8 && ec <= 11);
      ea = eg && (ec == (DUAL ? 15 : 11));
      chk("txt_late_grant", cpu_grant, eg);
      chk("txt_late_ack", cpu_ack, ea);
      if (ea) cpu_req = 1'b0;
    end

    // reset during a grant aborts it without ack
    while (ec != 5) adv_chk();
    cpu_req = 1'b1;
    while (ec != 9) adv_chk();
    chk("pre_rst_grant", cpu_grant, 1);
    reset = 1'b1;
    step();
    chk("abort_seq", clk_seq, 0);
    chk("abort_grant", cpu_grant, 0);
    chk("abort_ack", cpu_ack, 0);
    chk("abort_vram_read", vram_read, 0);
    cpu_req = 1'b0;
    step();
    chk("abort_ack2", cpu_ack, 0);
    reset = 1'b0;
    ec = 0; el = 17;
    for (int i = 0; i < 20; i++) begin
      adv_chk();
      chk("post_rst_grant", cpu_grant, 0);
      chk("post_rst_ack", cpu_ack, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
